// File: rtl/alu_exec.sv
// Execute stage: single-cycle ARM-style data-processing ALU plus a 32-iteration
// shift-add multiplier behind a start/busy/done handshake. Results and NZCV registered.
module alu_exec (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  ALUControl,
   input  logic        MulEn,
   input  logic        SetFlags,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic        busy,
   output logic        done,
   output logic [31:0] ALUResult,
   output logic        WriteEn,
   output logic [3:0]  ALUFlags
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 5;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   localparam int unsigned FN = 3;
   localparam int unsigned FZ = 2;
   localparam int unsigned FC = 1;
   localparam int unsigned FV = 0;

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [DW-1:0]    r_acc, w_acc_nxt;
   logic [DW-1:0]    r_ma, w_ma_nxt;
   logic [DW-1:0]    r_mb, w_mb_nxt;
   logic             r_mul_s, w_mul_s_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic             r_we, w_we_nxt;
   logic [DW-1:0]    r_result, w_result_nxt;
   logic [3:0]       r_flags, w_flags_nxt;

   logic [DW-1:0]    w_x, w_y;
   logic             w_cin;
   logic             w_arith;
   logic [DW:0]      w_sum;
   logic             w_ovf;
   logic [DW-1:0]    w_alu;
   logic             w_cmp_op;
   logic             w_upd;
   logic [DW-1:0]    w_mul_p;

   // Operand steering into one shared 33-bit adder; subtraction is x + ~y + cin
   always_comb begin
      w_x     = SrcA;
      w_y     = SrcB;
      w_cin   = 1'b0;
      w_arith = 1'b1;
      case (ALUControl)
         4'b0010, 4'b1010: begin
            w_y   = ~SrcB;
            w_cin = 1'b1;
         end
         4'b0011: begin
            w_x   = SrcB;
            w_y   = ~SrcA;
            w_cin = 1'b1;
         end
         4'b0100, 4'b1011: begin
            w_cin = 1'b0;
         end
         4'b0101: begin
            w_cin = r_flags[FC];
         end
         4'b0110: begin
            w_y   = ~SrcB;
            w_cin = r_flags[FC];
         end
         4'b0111: begin
            w_x   = SrcB;
            w_y   = ~SrcA;
            w_cin = r_flags[FC];
         end
         default: w_arith = 1'b0;
      endcase
      w_sum = {1'b0, w_x} + {1'b0, w_y} + (DW+1)'(w_cin);
      w_ovf = (w_x[DW-1] == w_y[DW-1]) && (w_sum[DW-1] != w_x[DW-1]);
   end

   // Logical results; arithmetic opcodes fall through to the adder
   always_comb begin
      case (ALUControl)
         4'b0000, 4'b1000: w_alu = SrcA & SrcB;
         4'b0001, 4'b1001: w_alu = SrcA ^ SrcB;
         4'b1100:          w_alu = SrcA | SrcB;
         4'b1101:          w_alu = SrcB;
         4'b1110:          w_alu = SrcA & ~SrcB;
         4'b1111:          w_alu = ~SrcB;
         default:          w_alu = w_sum[DW-1:0];
      endcase
   end

   assign w_cmp_op = (ALUControl[3:2] == 2'b10);
   assign w_upd    = SetFlags | w_cmp_op;
   assign w_mul_p  = r_acc + (r_mb[0] ? r_ma : '0);

   // Next-state and registered-output logic
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_acc_nxt    = r_acc;
      w_ma_nxt     = r_ma;
      w_mb_nxt     = r_mb;
      w_mul_s_nxt  = r_mul_s;
      w_busy_nxt   = 1'b0;
      w_done_nxt   = 1'b0;
      w_we_nxt     = 1'b0;
      w_result_nxt = r_result;
      w_flags_nxt  = r_flags;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (MulEn) begin
                  w_state_nxt = S_MUL;
                  w_busy_nxt  = 1'b1;
                  w_cnt_nxt   = '0;
                  w_acc_nxt   = '0;
                  w_ma_nxt    = SrcA;
                  w_mb_nxt    = SrcB;
                  w_mul_s_nxt = SetFlags;
               end else begin
                  w_done_nxt   = 1'b1;
                  w_we_nxt     = ~w_cmp_op;
                  w_result_nxt = w_alu;
                  if (w_upd) begin
                     w_flags_nxt[FN] = w_alu[DW-1];
                     w_flags_nxt[FZ] = (w_alu == '0);
                     // Logical ops leave C and V untouched
                     if (w_arith) begin
                        w_flags_nxt[FC] = w_sum[DW];
                        w_flags_nxt[FV] = w_ovf;
                     end
                  end
               end
            end
         end
         S_MUL: begin
            w_busy_nxt = 1'b1;
            w_acc_nxt  = w_mul_p;
            w_ma_nxt   = r_ma << 1;
            w_mb_nxt   = r_mb >> 1;
            w_cnt_nxt  = r_cnt + CW'(1);
            if (r_cnt == CW'(DW - 1)) begin
               w_state_nxt  = S_IDLE;
               w_busy_nxt   = 1'b0;
               w_done_nxt   = 1'b1;
               w_we_nxt     = 1'b1;
               w_cnt_nxt    = '0;
               w_result_nxt = w_mul_p;
               if (r_mul_s) begin
                  w_flags_nxt[FN] = w_mul_p[DW-1];
                  w_flags_nxt[FZ] = (w_mul_p == '0);
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_ma     <= '0;
         r_mb     <= '0;
         r_mul_s  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_we     <= 1'b0;
         r_result <= '0;
         r_flags  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_acc    <= w_acc_nxt;
         r_ma     <= w_ma_nxt;
         r_mb     <= w_mb_nxt;
         r_mul_s  <= w_mul_s_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_we     <= w_we_nxt;
         r_result <= w_result_nxt;
         r_flags  <= w_flags_nxt;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign WriteEn   = r_we;
   assign ALUResult = r_result;
   assign ALUFlags  = r_flags;

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec: ALU ops, flags, multiply latency,
// busy-ignore, back-to-back issue and reset abort mid-multiply.
module tb_alu_exec;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  ALUControl;
   logic        MulEn;
   logic        SetFlags;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        busy;
   logic        done;
   logic [31:0] ALUResult;
   logic        WriteEn;
   logic [3:0]  ALUFlags;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc;
   int n_done;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_BIC = 4'b1110;
   localparam logic [3:0] OP_MVN = 4'b1111;

   alu_exec dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .ALUControl (ALUControl),
      .MulEn      (MulEn),
      .SetFlags   (SetFlags),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .busy       (busy),
      .done       (done),
      .ALUResult  (ALUResult),
      .WriteEn    (WriteEn),
      .ALUFlags   (ALUFlags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [3:0] c, input logic m, input logic s,
                        input logic [31:0] a, input logic [31:0] b);
      start      = 1'b1;
      ALUControl = c;
      MulEn      = m;
      SetFlags   = s;
      SrcA       = a;
      SrcB       = b;
   endtask

   // Wait for done after a MUL start edge; cyc counts cycles since start
   task automatic wait_done();
      while (done !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      ALUControl = 4'h0;
      MulEn = 1'b0;
      SetFlags = 1'b0;
      SrcA = '0;
      SrcB = '0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_we", 32'(WriteEn), 32'd0);
      check("rst_result", ALUResult, 32'h0);
      check("rst_flags", 32'(ALUFlags), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // Carry chain
      issue(OP_ADD, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1);
      tick();
      check("add_carry_done", 32'(done), 32'd1);
      check("add_carry_we", 32'(WriteEn), 32'd1);
      check("add_carry_res", ALUResult, 32'h0);
      check("add_carry_flags", 32'(ALUFlags), 32'b0110);
      issue(OP_ADC, 1'b0, 1'b1, 32'd2, 32'd3);
      tick();
      check("adc_res", ALUResult, 32'd6);
      check("adc_flags", 32'(ALUFlags), 32'b0000);
      issue(OP_SBC, 1'b0, 1'b0, 32'd10, 32'd3);
      tick();
      check("sbc_res", ALUResult, 32'd6);
      check("sbc_flags", 32'(ALUFlags), 32'b0000);
      issue(OP_AND, 1'b0, 1'b1, 32'hF0, 32'h0F);
      tick();
      check("and_res", ALUResult, 32'h0);
      check("and_flags", 32'(ALUFlags), 32'b0100);
      start = 1'b0;
      tick();
      check("idle_done", 32'(done), 32'd0);
      check("idle_hold_res", ALUResult, 32'h0);
      check("idle_hold_flags", 32'(ALUFlags), 32'b0100);

      // Multiply with latency measurement and an ignored start during busy
      issue(OP_ADD, 1'b1, 1'b0, 32'h1234_5678, 32'h10);
      tick();
      cyc = 1;
      check("mul1_busy_first", 32'(busy), 32'd1);
      check("mul1_done_first", 32'(done), 32'd0);
      start = 1'b0;
      while (done !== 1'b1 && cyc < 40) begin
         if (cyc == 5) issue(OP_ADD, 1'b0, 1'b1, 32'd7, 32'd7);
         else start = 1'b0;
         tick();
         cyc++;
         if (cyc == 32) check("mul1_busy_last", 32'(busy), 32'd1);
      end
      start = 1'b0;
      check("mul1_latency", 32'(cyc), 32'd33);
      check("mul1_busy_done", 32'(busy), 32'd0);
      check("mul1_res", ALUResult, 32'h2345_6780);
      check("mul1_we", 32'(WriteEn), 32'd1);
      check("mul1_flags", 32'(ALUFlags), 32'b0100);
      tick();
      check("mul1_no_queue_done", 32'(done), 32'd0);
      check("mul1_no_queue_res", ALUResult, 32'h2345_6780);

      // Signed overflow
      issue(OP_ADD, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h1);
      tick();
      check("ovf_done", 32'(done), 32'd1);
      check("ovf_we", 32'(WriteEn), 32'd1);
      check("ovf_res", ALUResult, 32'h8000_0000);
      check("ovf_flags", 32'(ALUFlags), 32'b1001);

      // Compare forces flag update without write
      issue(OP_CMP, 1'b0, 1'b0, 32'd5, 32'd5);
      tick();
      check("cmp_done", 32'(done), 32'd1);
      check("cmp_we", 32'(WriteEn), 32'd0);
      check("cmp_flags", 32'(ALUFlags), 32'b0110);
      issue(OP_SUB, 1'b0, 1'b0, 32'd3, 32'd5);
      tick();
      check("sub_res", ALUResult, 32'hFFFF_FFFE);
      check("sub_we", 32'(WriteEn), 32'd1);
      check("sub_flags", 32'(ALUFlags), 32'b0110);

      // Multiply with S: N/Z updated, C/V preserved
      issue(OP_ADD, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tick();
      cyc = 1;
      start = 1'b0;
      wait_done();
      check("mul2_latency", 32'(cyc), 32'd33);
      check("mul2_res", ALUResult, 32'h1);
      check("mul2_flags", 32'(ALUFlags), 32'b0010);

      // Back-to-back, first start issued in the done cycle
      issue(OP_MOV, 1'b0, 1'b0, 32'h0, 32'h1);
      tick();
      check("b2b_mov_done", 32'(done), 32'd1);
      check("b2b_mov_res", ALUResult, 32'h1);
      issue(OP_MVN, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      check("b2b_mvn_done", 32'(done), 32'd1);
      check("b2b_mvn_res", ALUResult, 32'hFFFF_FFFF);
      issue(OP_ORR, 1'b0, 1'b0, 32'hF0, 32'h0F);
      tick();
      check("b2b_orr_done", 32'(done), 32'd1);
      check("b2b_orr_res", ALUResult, 32'hFF);
      issue(OP_BIC, 1'b0, 1'b0, 32'hFF, 32'h0F);
      tick();
      check("b2b_bic_done", 32'(done), 32'd1);
      check("b2b_bic_res", ALUResult, 32'hF0);
      check("b2b_flags", 32'(ALUFlags), 32'b0010);
      start = 1'b0;
      tick();
      check("b2b_end_done", 32'(done), 32'd0);

      // Reset in the middle of a multiply
      issue(OP_ADD, 1'b1, 1'b1, 32'd3, 32'd5);
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check("rmul_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rmul_busy", 32'(busy), 32'd0);
      check("rmul_done", 32'(done), 32'd0);
      check("rmul_we", 32'(WriteEn), 32'd0);
      check("rmul_res", ALUResult, 32'h0);
      check("rmul_flags", 32'(ALUFlags), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1) n_done++;
      end
      check("rmul_no_done", 32'(n_done), 32'd0);
      check("rmul_busy_after", 32'(busy), 32'd0);
      issue(OP_ADD, 1'b0, 1'b0, 32'd1, 32'd1);
      tick();
      check("post_rst_add_done", 32'(done), 32'd1);
      check("post_rst_add_res", ALUResult, 32'd2);
      start = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute stage of the MCU datapath, directly downstream of the barrel shifter. Takes operand A from the register file and operand B (the shifted/immediate operand produced by the shifter) and executes one ARM-style data-processing instruction or a 32x32 multiply. Results and flags are registered. Multiply is a 32-iteration shift-add sequencer behind a start/busy/done handshake, so the controller stalls only on MUL.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when idle (busy=0).
- ALUControl  in  4  data-processing opcode (ARM encoding, below).
- MulEn  in  1  1 = multiply (ALUControl ignored).
- SetFlags  in  1  S-bit; update NZCV on completion.
- SrcA  in  32  operand A (Rn).
- SrcB  in  32  operand B (shifter output).
- busy  out  1  multiply in progress; start ignored.
- done  out  1  one-cycle pulse; ALUResult/flags valid from this cycle.
- ALUResult  out  32  registered result, held until next done.
- WriteEn  out  1  with done: result goes to Rd (0 for TST/TEQ/CMP/CMN).
- ALUFlags  out  4  NZCV register {N,Z,C,V}.

## Operation
- Opcodes: 0000 AND, 0001 EOR, 0010 SUB (A-B), 0011 RSB (B-A), 0100 ADD, 0101 ADC (A+B+C), 0110 SBC (A-B-!C), 0111 RSC (B-A-!C), 1000 TST, 1001 TEQ, 1010 CMP, 1011 CMN, 1100 ORR, 1101 MOV (B), 1110 BIC (A&~B), 1111 MVN (~B).
- Operands sampled at the start edge; SrcA/SrcB may change afterwards.
- Arithmetic uses a 33-bit sum. Subtraction is A+~B+1, so C = NOT borrow. V = signed overflow of the 32-bit operation.
- Logical ops update N and Z; C and V are preserved.
- Flag update condition: SetFlags=1, or the opcode is 1000–1011. Compare ops force a flag update.
- Z = (result==0); N = result[31].
- Multiply returns the low 32 bits of SrcA*SrcB.
  - Iterative: acc += (mb[0] ? ma : 0); ma <<= 1; mb >>= 1; 5-bit counter.
  - Updates N and Z only (if SetFlags); C and V are preserved.
- FSM:
  - IDLE: start & MulEn -> MUL; start & !MulEn -> compute, done next cycle, stay IDLE.
  - MUL: 32 iterations, then -> IDLE with done.
- WriteEn = done & opcode not in 1000–1011; WriteEn = done for MUL.

## Timing
- Reset values: busy=0, done=0, WriteEn=0, ALUResult=0, ALUFlags=0000, FSM=IDLE, counter=0.
- ALU op:
  - start sampled at edge T0.
  - done/WriteEn/ALUResult/ALUFlags updated at edge T0+1.
  - Latency 1 cycle; throughput 1 op per cycle (start may be held high continuously).
- MUL:
  - start at T0; busy=1 from T0+1 through T0+32.
  - done=1, busy=0 at T0+33; latency 33.
- start while busy=1 is ignored and is not queued.
- start in the done cycle is accepted (FSM already IDLE).
- rst_n low at any time, including mid-multiply: immediate abort, all outputs to reset values, no done.
- ALUResult and ALUFlags are stable between done pulses.

## Test plan
- Reset mid-MUL:
  - start MUL 3*5, assert rst_n=0 at iteration 10 -> busy=0, done never pulses, ALUFlags=0000, ALUResult=0.
  - Following ADD 1+1 -> 2 after 1 cycle.
- Add overflow: ADD 0x7FFFFFFF+1, SetFlags=1 -> ALUResult=0x80000000, NZCV=1001, done/WriteEn at T0+1.
- Compare ops:
  - CMP 5,5 -> NZCV=0110, WriteEn=0 even with SetFlags=0.
  - SUB 3-5, SetFlags=0 -> ALUResult=0xFFFFFFFE, flags unchanged.
- Carry chain:
  - ADD 0xFFFFFFFF+1 (S) -> C=1, Z=1.
  - Then ADC 2+3 -> 6.
  - Then SBC 10-3 with C=0 -> 6.
  - Then AND 0xF0&0x0F (S) -> Z=1, C still 0.
- Multiply:
  - 0x12345678*0x10 -> 0x23456780, done exactly 33 cycles after start.
  - 0xFFFFFFFF*0xFFFFFFFF (S) -> ALUResult=1, N=0, Z=0, C/V preserved.
  - start pulses during busy are ignored.
- Back-to-back: start held high for 4 cycles with MOV 1, MVN 0, ORR 0xF0|0x0F, BIC 0xFF&~0x0F -> done high 4 consecutive cycles, results 1, 0xFFFFFFFF, 0xFF, 0xF0.
